axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Two-master read arbiter that shares the core's single AXI read port between the instruction-cache refill master and the data-cache refill master. It sits between the cache miss engines and the AXI bridge. It grants one requester at a time with round-robin fairness and drives the AR fields the caches do not supply: ID, length, size and burst. It steers the R channel back to the granted requester until the last beat, and flags length or ID mismatches.

## Interface
Parameters:
- I_ARLEN, 8'd7: AXI arlen for inst requests (8-word line).
- D_ARLEN, 8'd7: AXI arlen for data requests.
- I_ARID, 4'd0: AXI arid for inst requests.
- D_ARID, 4'd1: AXI arid for data requests.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_araddr  in  32  inst requester address.
- i_arvalid  in  1  inst address valid; held until i_arready.
- i_arready  out  1  inst address accepted.
- i_rdata  out  32  inst read data.
- i_rvalid  out  1  inst beat valid.
- i_rlast  out  1  inst last beat.
- i_rready  in  1  inst beat accept.
- d_araddr, d_arvalid, d_arready, d_rdata, d_rvalid, d_rlast, d_rready: data requester; same widths and meanings.
- m_arid  out  4  AXI read ID.
- m_araddr  out  32  AXI read address.
- m_arlen  out  8  AXI burst length.
- m_arsize  out  3  constant 3'b010.
- m_arburst  out  2  constant 2'b01 (INCR).
- m_arvalid  out  1  AXI address valid.
- m_arready  in  1  AXI address ready.
- m_rid  in  4  AXI response ID.
- m_rdata  in  32  AXI read data.
- m_rresp  in  2  AXI response (checked, not forwarded).
- m_rlast  in  1  AXI last beat.
- m_rvalid  in  1  AXI data valid.
- m_rready  out  1  AXI data ready.
- burst_err  out  1  sticky protocol error flag.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any *_arvalid is high, register the grant and go to ADDR. Also latch m_araddr, m_arid and m_arlen from the winner's parameters, and clear the beat counter.
  - Only one requester: it wins.
  - Both requesters: the one not granted last wins. The last-grant bit resets to data, so inst wins the first tie.
- ADDR: m_arvalid=1 and the AR fields are held stable. On m_arvalid&m_arready:
  - pulse the granted *_arready for that same cycle (combinational, = m_arready);
  - go to DATA;
  - update the last-grant bit.
- DATA: R channel routed to the granted port only.
  - m_rready = granted *_rready.
  - Granted *_rvalid/*_rdata/*_rlast = m_rvalid/m_rdata/m_rlast. The other port's rvalid stays 0.
  - Beat counter (8-bit) increments on each m_rvalid&m_rready.
- End of burst: on the m_rlast beat accepted, go to IDLE.
- burst_err: set (and held until rst) on any accepted beat where any of the following holds:
  - m_rid ≠ latched arid;
  - m_rresp ≠ 2'b00;
  - m_rlast=1 with counter ≠ latched arlen;
  - counter = latched arlen with m_rlast=0.
- Requests that arrive in ADDR/DATA wait; requesters hold arvalid.
- Responses are steered by grant, not by rid (single outstanding transaction).

## Timing
- Reset values: all outputs 0 except m_arsize=3'b010 and m_arburst=2'b01. State IDLE, last-grant=data, burst_err=0.
- rst mid-burst forces IDLE immediately with no drain; rst is shared with the AXI slave.
- Request in IDLE at cycle N: m_arvalid=1 at N+1.
- AR handshake at cycle M: DATA at M+1; beats pass with zero latency (combinational).
- rlast accepted at cycle L: IDLE at L+1. The next m_arvalid is at L+2 at the earliest.
- m_arvalid never drops before m_arready; AR fields never change while m_arvalid=1.
- m_rvalid seen in IDLE/ADDR is ignored (m_rready=0) and sets burst_err.

## Structure
- Shared package (cpu_axi_pkg): AXI_SIZE_WORD=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, the line-length constant 8'd7, and the state enum.
- One sub-module is natural: rr_arbiter2 (2-input round-robin pick, last-grant register with enable).

## Test plan
- Inst-only request, addr 0x1FC0_0000, slave returns 8 beats 0x0..0x7 → m_arid=0, m_arlen=7, i_arready one cycle, i_rdata sequence 0..7, i_rlast on beat 8, burst_err=0.
- Both arvalid high in the same cycle after reset → inst granted first, data granted at rlast+2, m_arid=1, d_rdata delivered; d_rvalid never high during the inst burst.
- Back-to-back contention (both held high for 4 bursts) → grants alternate I,D,I,D.
- Slave holds m_arready low for 5 cycles, and the data requester toggles i_/d_ inputs → m_araddr/m_arlen stable throughout, single handshake.
- Each of the following → burst_err=1 and held until rst: m_rlast on beat 5 of 8; m_rid=3 on a data burst; m_rresp=2'b10.
- rst asserted during beat 3 → next cycle all outputs at reset values, state IDLE; a new inst request completes normally.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// Shared AXI read-side constants, arbiter state encoding and latched AR request.
package cpu_axi_pkg;

   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [7:0] AXI_LINE_LEN   = 8'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rd_state_e;

   // AR fields owned by the arbiter for the transaction in flight.
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } ar_req_t;

endpackage

// File: rtl/axi_read_arbiter_rr.sv
// Two-input round-robin pick with a last-grant register (1 = data granted last).
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic req_d,
   input  logic upd_en,
   input  logic upd_d,
   output logic pick_d,
   output logic any_req
);

   logic last_d;

   // Last-grant history; starts at data so inst wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         last_d <= 1'b1;
      else if (upd_en)
         last_d <= upd_d;
   end

   // Data wins when alone, or on a tie when inst was granted last.
   always_comb begin
      any_req = req_i | req_d;
      pick_d  = req_d & (~req_i | ~last_d);
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port between the inst and data cache refill masters.
// One outstanding burst at a time; R beats are steered by grant, not by rid.
module axi_read_arbiter
   import cpu_axi_pkg::*;
#(
   parameter logic [7:0] I_ARLEN = AXI_LINE_LEN,
   parameter logic [7:0] D_ARLEN = AXI_LINE_LEN,
   parameter logic [3:0] I_ARID  = 4'd0,
   parameter logic [3:0] D_ARID  = 4'd1
)(
   input  logic        clk,
   input  logic        rst,
   // inst requester
   input  logic [31:0] i_araddr,
   input  logic        i_arvalid,
   output logic        i_arready,
   output logic [31:0] i_rdata,
   output logic        i_rvalid,
   output logic        i_rlast,
   input  logic        i_rready,
   // data requester
   input  logic [31:0] d_araddr,
   input  logic        d_arvalid,
   output logic        d_arready,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   output logic        d_rlast,
   input  logic        d_rready,
   // AXI read master
   output logic [3:0]  m_arid,
   output logic [31:0] m_araddr,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [3:0]  m_rid,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic        burst_err
);

   rd_state_e  state, state_nx;
   ar_req_t    ar_lat;
   logic       grant_d;
   logic [7:0] beat_cnt;
   logic       pick_d;
   logic       any_req;
   logic       start;
   logic       ar_hs;
   logic       r_hs;
   logic       beat_bad;

   assign start = (state == ST_IDLE) && any_req;
   assign ar_hs = (state == ST_ADDR) && m_arready;
   assign r_hs  = (state == ST_DATA) && m_rvalid && m_rready;

   // A beat is malformed if it carries the wrong id, a non-OKAY response,
   // or its rlast disagrees with the beat count expected from arlen.
   assign beat_bad = (m_rid != ar_lat.id)
                  || (m_rresp != AXI_RESP_OKAY)
                  || (m_rlast && (beat_cnt != ar_lat.len))
                  || ((beat_cnt == ar_lat.len) && !m_rlast);

   rr_arbiter2 u_rr (
      .clk     (clk),
      .rst     (rst),
      .req_i   (i_arvalid),
      .req_d   (d_arvalid),
      .upd_en  (ar_hs),
      .upd_d   (grant_d),
      .pick_d  (pick_d),
      .any_req (any_req)
   );

   assign m_arid    = ar_lat.id;
   assign m_araddr  = ar_lat.addr;
   assign m_arlen   = ar_lat.len;
   assign m_arsize  = AXI_SIZE_WORD;
   assign m_arburst = AXI_BURST_INCR;

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Grant and AR fields are captured once in IDLE and held for the whole burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_d <= 1'b0;
         ar_lat  <= '0;
      end else if (start) begin
         grant_d <= pick_d;
         if (pick_d)
            ar_lat <= '{id: D_ARID, addr: d_araddr, len: D_ARLEN};
         else
            ar_lat <= '{id: I_ARID, addr: i_araddr, len: I_ARLEN};
      end
   end

   // Beat counter: cleared at grant, advanced on each accepted R beat.
   always_ff @(posedge clk) begin
      if (rst)
         beat_cnt <= 8'd0;
      else if (start)
         beat_cnt <= 8'd0;
      else if (r_hs)
         beat_cnt <= beat_cnt + 8'd1;
   end

   // Sticky protocol error: bad accepted beat, or any R traffic outside DATA.
   always_ff @(posedge clk) begin
      if (rst)
         burst_err <= 1'b0;
      else if ((r_hs && beat_bad) || (m_rvalid && (state != ST_DATA)))
         burst_err <= 1'b1;
   end

   // Next state plus AR/R steering; the non-granted side always sees zeros.
   always_comb begin
      state_nx  = state;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      i_arready = 1'b0;
      d_arready = 1'b0;
      i_rvalid  = 1'b0;
      i_rdata   = '0;
      i_rlast   = 1'b0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      d_rlast   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_req)
               state_nx = ST_ADDR;
         end
         ST_ADDR: begin
            m_arvalid = 1'b1;
            if (m_arready) begin
               i_arready = ~grant_d;
               d_arready = grant_d;
               state_nx  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (grant_d) begin
               m_rready = d_rready;
               d_rvalid = m_rvalid;
               d_rdata  = m_rdata;
               d_rlast  = m_rlast;
            end else begin
               m_rready = i_rready;
               i_rvalid = m_rvalid;
               i_rdata  = m_rdata;
               i_rlast  = m_rlast;
            end
            if (m_rvalid && m_rready && m_rlast)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule
